qea_host_ctrl: RTL and testbench

QEA_HOST_CTRL -- requirements
Module: qea_host_ctrl

---
 rtl/qea_pkg.sv | 27 ++
 rtl/qea_host_ctrl_if.sv | 30 +++
 rtl/qea_host_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_qea_host_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qea_pkg.sv
// rtl/qea_pkg.sv - shared widths, FSM state encoding and fixed-point constants for the QEA host controller
package qea_pkg;

    localparam int DEF_PE_NUM                  = 4;
    localparam int DEF_DATA_WIDTH              = 32;
    localparam int DEF_STATE_DATA_WIDTH        = 2 * DEF_DATA_WIDTH;
    localparam int DEF_STATE_ADDR_WIDTH        = 16;
    localparam int DEF_GATE_CONTEXT_DATA_WIDTH = 64;
    localparam int DEF_GATE_CONTEXT_ADDR_WIDTH = 16;
    localparam int DEF_MAX_QBIT_WIDTH          = 6;

    // Amplitude 1.0 in Q2.30
    localparam logic [31:0] Q2_30_ONE = 32'h4000_0000;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_CTX,
        LOAD_STATE,
        START,
        WAIT,
        RD_ADDR,
        RD_LAT,
        RD_OUT,
        DONE
    } state_e;

endpackage

// File: rtl/qea_host_ctrl_if.sv
// rtl/qea_host_ctrl_if.sv - context input stream and readout stream between host and controller
interface qea_host_ctrl_if
    import qea_pkg::*;
#(
    parameter int PE_NUM                  = DEF_PE_NUM,
    parameter int STATE_DATA_WIDTH        = DEF_STATE_DATA_WIDTH,
    parameter int GATE_CONTEXT_DATA_WIDTH = DEF_GATE_CONTEXT_DATA_WIDTH
);
    logic                                 i_ctx_valid;
    logic                                 o_ctx_ready;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word;

    logic                                 o_rd_valid;
    logic                                 i_rd_ready;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data;
    logic                                 o_rd_last;

    // Controller side: sinks the context stream, sources the readout stream
    modport master (
        input  i_ctx_valid, i_ctx_word, i_rd_ready,
        output o_ctx_ready, o_rd_valid, o_rd_data, o_rd_last
    );

    // Host side
    modport slave (
        output i_ctx_valid, i_ctx_word, i_rd_ready,
        input  o_ctx_ready, o_rd_valid, o_rd_data, o_rd_last
    );

endinterface

// File: rtl/qea_host_ctrl.sv
// rtl/qea_host_ctrl.sv - host sequencer: loads gate context and initial state, runs the QEA, streams the state back
module qea_host_ctrl
    import qea_pkg::*;
#(
    parameter int PE_NUM                  = DEF_PE_NUM,
    parameter int DATA_WIDTH              = DEF_DATA_WIDTH,
    parameter int STATE_DATA_WIDTH        = 2 * DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = DEF_STATE_ADDR_WIDTH,
    parameter int GATE_CONTEXT_DATA_WIDTH = DEF_GATE_CONTEXT_DATA_WIDTH,
    parameter int GATE_CONTEXT_ADDR_WIDTH = DEF_GATE_CONTEXT_ADDR_WIDTH,
    parameter int MAX_QBIT_WIDTH          = DEF_MAX_QBIT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic                                  i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]             i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    i_ins_num,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_err,
    output logic [31:0]                           o_cycles,

    qea_host_ctrl_if.master                       bus,

    output logic                                  o_start,
    output logic [MAX_QBIT_WIDTH-1:0]             o_qbit_num,
    output logic                                  o_ctx_en,
    output logic                                  o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]    o_ctx_data,
    output logic [PE_NUM-1:0]                     o_state_ena,
    output logic [PE_NUM-1:0]                     o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]           o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_state_dina,
    input  logic                                  i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]    i_state_dout
);

    localparam int LANES_W = PE_NUM * STATE_DATA_WIDTH;
    localparam int CW      = STATE_ADDR_WIDTH + 1;

    // |0> basis word: real part 1.0 at the top of the top lane, everything else zero
    localparam logic [DATA_WIDTH-1:0] ONE_RE     = DATA_WIDTH'(Q2_30_ONE);
    localparam logic [LANES_W-1:0]    INIT_WORD0 = {ONE_RE, {(LANES_W-DATA_WIDTH){1'b0}}};

    state_e                               state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_q, qbit_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_q, ins_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_cnt_q, ctx_cnt_d;
    logic [STATE_ADDR_WIDTH-1:0]          last_q, last_d;
    logic [STATE_ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [31:0]                          cycles_q, cycles_d;
    logic                                 err_q, err_d;
    logic [LANES_W-1:0]                   rd_data_q, rd_data_d;

    logic                                 qbit_ok;
    logic [CW-1:0]                        n_words;

    // Legal range keeps 2^(qbit_num-2) words within the state RAM address space
    assign qbit_ok = (int'(i_qbit_num) >= 2) && (int'(i_qbit_num) <= STATE_ADDR_WIDTH + 2);
    assign n_words = CW'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(2));

    assign o_busy     = (state_q != IDLE);
    assign o_err      = err_q;
    assign o_cycles   = cycles_q;
    assign o_qbit_num = qbit_q;
    assign bus.o_rd_data = rd_data_q;

    // State and datapath registers; reset aborts any run in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            qbit_q    <= '0;
            ins_q     <= '0;
            ctx_cnt_q <= '0;
            last_q    <= '0;
            addr_q    <= '0;
            cycles_q  <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            qbit_q    <= qbit_d;
            ins_q     <= ins_d;
            ctx_cnt_q <= ctx_cnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            cycles_q  <= cycles_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Next-state and output decode; every output idles low outside the states that drive it
    always_comb begin
        state_d   = state_q;
        qbit_d    = qbit_q;
        ins_d     = ins_q;
        ctx_cnt_d = ctx_cnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        cycles_d  = cycles_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;

        o_done          = 1'b0;
        o_start         = 1'b0;
        o_ctx_en        = 1'b0;
        o_ctx_wea       = 1'b0;
        o_ctx_addr      = '0;
        o_ctx_data      = '0;
        o_state_ena     = '0;
        o_state_wea     = '0;
        o_state_addra   = '0;
        o_state_dina    = '0;
        bus.o_ctx_ready = 1'b0;
        bus.o_rd_valid  = 1'b0;
        bus.o_rd_last   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_go) begin
                    qbit_d    = i_qbit_num;
                    ins_d     = i_ins_num;
                    ctx_cnt_d = '0;
                    addr_d    = '0;
                    last_d    = STATE_ADDR_WIDTH'(n_words - CW'(1));
                    if (!qbit_ok) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (i_ins_num == '0) ? LOAD_STATE : LOAD_CTX;
                    end
                end
            end
            LOAD_CTX: begin
                bus.o_ctx_ready = 1'b1;
                if (bus.i_ctx_valid) begin
                    o_ctx_en   = 1'b1;
                    o_ctx_wea  = 1'b1;
                    o_ctx_addr = ctx_cnt_q;
                    o_ctx_data = bus.i_ctx_word;
                    ctx_cnt_d  = ctx_cnt_q + GATE_CONTEXT_ADDR_WIDTH'(1);
                    if (ctx_cnt_q == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
                        state_d = LOAD_STATE;
                    end
                end
            end
            LOAD_STATE: begin
                o_state_ena   = '1;
                o_state_wea   = '1;
                o_state_addra = addr_q;
                o_state_dina  = (addr_q == '0) ? INIT_WORD0 : '0;
                addr_d        = addr_q + STATE_ADDR_WIDTH'(1);
                if (addr_q == last_q) begin
                    state_d = START;
                end
            end
            START: begin
                o_start  = 1'b1;
                cycles_d = '0;
                addr_d   = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                // The completion cycle itself is counted, so o_cycles equals start-to-complete distance
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (i_complete) begin
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                o_state_ena   = '1;
                o_state_addra = addr_q;
                state_d       = RD_LAT;
            end
            RD_LAT: begin
                // RAM read data is valid one cycle after the address
                rd_data_d = i_state_dout;
                state_d   = RD_OUT;
            end
            RD_OUT: begin
                bus.o_rd_valid = 1'b1;
                bus.o_rd_last  = (addr_q == last_q);
                if (bus.i_rd_ready) begin
                    if (addr_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + STATE_ADDR_WIDTH'(1);
                        state_d = RD_ADDR;
                    end
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qea_host_ctrl.sv
// tb/tb_qea_host_ctrl.sv - randomized directed bench for qea_host_ctrl against a behavioural run model
module tb_qea_host_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_go;
    logic [5:0]    i_qbit_num;
    logic [15:0]   i_ins_num;
    logic          o_busy, o_done, o_err;
    logic [31:0]   o_cycles;
    logic          o_start;
    logic [5:0]    o_qbit_num;
    logic          o_ctx_en, o_ctx_wea;
    logic [15:0]   o_ctx_addr;
    logic [63:0]   o_ctx_data;
    logic [3:0]    o_state_ena, o_state_wea;
    logic [15:0]   o_state_addra;
    logic [255:0]  o_state_dina;
    logic          i_complete;
    logic [255:0]  i_state_dout;

    qea_host_ctrl_if bus ();

    qea_host_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_go          (i_go),
        .i_qbit_num    (i_qbit_num),
        .i_ins_num     (i_ins_num),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_cycles      (o_cycles),
        .bus           (bus),
        .o_start       (o_start),
        .o_qbit_num    (o_qbit_num),
        .o_ctx_en      (o_ctx_en),
        .o_ctx_wea     (o_ctx_wea),
        .o_ctx_addr    (o_ctx_addr),
        .o_ctx_data    (o_ctx_data),
        .o_state_ena   (o_state_ena),
        .o_state_wea   (o_state_wea),
        .o_state_addra (o_state_addra),
        .o_state_dina  (o_state_dina),
        .i_complete    (i_complete),
        .i_state_dout  (i_state_dout)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    // QEA memory image the emulated accelerator leaves behind
    logic [255:0] qea_img [0:255];
    logic         qea_load;
    logic [255:0] mem [0:255];

    // Monitor records (written only by the monitor)
    logic [15:0]  ctx_addr_q [$];
    logic [63:0]  ctx_data_q [$];
    logic [15:0]  st_addr_q  [$];
    logic [255:0] st_data_q  [$];
    logic [255:0] rd_data_q  [$];
    logic         rd_last_q  [$];
    int start_cnt = 0, done_cnt = 0, rd_issue_cnt = 0, en_cnt = 0, bad_en_cnt = 0;

    // State RAM with one-cycle read latency; qea_load models the accelerator rewriting it
    always @(posedge clk) begin
        if (qea_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= qea_img[i];
        end else if (|o_state_ena) begin
            if (|o_state_wea) mem[o_state_addra[7:0]] <= o_state_dina;
            else              i_state_dout <= mem[o_state_addra[7:0]];
        end
    end

    always @(negedge clk) begin
        if (o_ctx_en) begin
            ctx_addr_q.push_back(o_ctx_addr);
            ctx_data_q.push_back(o_ctx_data);
            if (!o_ctx_wea) bad_en_cnt++;
        end
        if (|o_state_wea) begin
            st_addr_q.push_back(o_state_addra);
            st_data_q.push_back(o_state_dina);
            if (o_state_ena != 4'hf || o_state_wea != 4'hf) bad_en_cnt++;
        end else if (|o_state_ena) begin
            rd_issue_cnt++;
            if (o_state_ena != 4'hf) bad_en_cnt++;
        end
        if (o_start) start_cnt++;
        if (o_done)  done_cnt++;
        if (o_ctx_en || o_ctx_wea || (|o_state_ena) || (|o_state_wea) || o_start) en_cnt++;
        if (bus.o_rd_valid && bus.i_rd_ready) begin
            rd_data_q.push_back(bus.o_rd_data);
            rd_last_q.push_back(bus.o_rd_last);
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One legal run: drive it end to end, then compare everything the QEA side saw with the model
    task automatic run_legal(input string name, input int q, input int ins, input bit gap,
                             input int stall_word, input int delay, input bit busy_go);
        int n, b_ctx, b_st, b_rd, b_start, b_done, b_iss, b_bad;
        int idx, cyc, words, stall_left, iss_stall, iss_after, bad;
        bit seen, stable, vdrop;
        logic [63:0]  words_in [$];
        logic [255:0] held, init_word;

        n = 1 << (q - 2);
        init_word = '0;
        init_word[255:224] = 32'h4000_0000;
        b_ctx = ctx_addr_q.size(); b_st = st_addr_q.size(); b_rd = rd_data_q.size();
        b_start = start_cnt; b_done = done_cnt; b_iss = rd_issue_cnt; b_bad = bad_en_cnt;
        for (int i = 0; i < ins; i++) words_in.push_back({$urandom(), $urandom()});
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 8; k++) qea_img[i][k*32 +: 32] = $urandom();

        @(posedge clk); #1;
        i_qbit_num = 6'(q); i_ins_num = 16'(ins); i_go = 1'b1;
        @(posedge clk); #1;
        i_go = 1'b0;

        idx = 0; cyc = 0;
        while (idx < ins && cyc < 3000) begin
            bus.i_ctx_valid = gap ? (cyc % 2 == 0) : 1'b1;
            bus.i_ctx_word  = words_in[idx];
            @(negedge clk);
            seen = bus.i_ctx_valid && bus.o_ctx_ready;
            @(posedge clk); #1;
            if (seen) idx++;
            cyc++;
        end
        bus.i_ctx_valid = 1'b0;
        check({name, " ctx_feed_done"}, 256'(idx), 256'(ins));

        if (busy_go) begin i_qbit_num = 6'd2; i_ins_num = 16'd0; end
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 3000) begin
            i_go = busy_go && (cyc == 0);
            @(negedge clk);
            seen = o_start;
            @(posedge clk); #1;
            cyc++;
        end
        i_go = 1'b0;
        check({name, " start_seen"}, 256'(seen), 256'(1));

        repeat (delay - 1) @(posedge clk);
        #1;
        i_complete = 1'b1; qea_load = 1'b1;
        @(posedge clk); #1;
        i_complete = 1'b0; qea_load = 1'b0;

        words = 0; cyc = 0; stall_left = 5; stable = 1'b1; vdrop = 1'b0;
        iss_stall = 0; iss_after = 0;
        while (words < n && cyc < 3000) begin
            bus.i_rd_ready = !(words == stall_word && stall_left > 0);
            @(negedge clk);
            if (words == stall_word && stall_left > 0 && stall_left < 5 && !bus.o_rd_valid) vdrop = 1'b1;
            if (bus.o_rd_valid) begin
                if (bus.i_rd_ready) begin
                    words++;
                end else begin
                    if (stall_left == 5) begin held = bus.o_rd_data; iss_stall = rd_issue_cnt; end
                    else if (bus.o_rd_data !== held) stable = 1'b0;
                    stall_left--;
                    if (stall_left == 0) iss_after = rd_issue_cnt;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.i_rd_ready = 1'b1;
        cyc = 0;
        while (o_busy && cyc < 20) begin @(posedge clk); #1; cyc++; end

        check({name, " ctx_writes"}, 256'(ctx_addr_q.size() - b_ctx), 256'(ins));
        bad = 0;
        for (int i = 0; i < ins && b_ctx + i < ctx_addr_q.size(); i++)
            if (ctx_addr_q[b_ctx+i] !== 16'(i) || ctx_data_q[b_ctx+i] !== words_in[i]) bad++;
        check({name, " ctx_addr_data_bad"}, 256'(bad), 256'(0));
        check({name, " state_writes"}, 256'(st_addr_q.size() - b_st), 256'(n));
        bad = 0;
        for (int i = 0; i < n && b_st + i < st_addr_q.size(); i++)
            if (st_addr_q[b_st+i] !== 16'(i) || st_data_q[b_st+i] !== ((i == 0) ? init_word : 256'(0))) bad++;
        check({name, " state_words_bad"}, 256'(bad), 256'(0));
        check({name, " enable_pattern_bad"}, 256'(bad_en_cnt - b_bad), 256'(0));
        check({name, " start_pulses"}, 256'(start_cnt - b_start), 256'(1));
        check({name, " cycles"}, 256'(o_cycles), 256'(delay));
        check({name, " readout_words"}, 256'(rd_data_q.size() - b_rd), 256'(n));
        bad = 0;
        for (int i = 0; i < n && b_rd + i < rd_data_q.size(); i++)
            if (rd_data_q[b_rd+i] !== qea_img[i] || rd_last_q[b_rd+i] !== (i == n - 1)) bad++;
        check({name, " readout_data_last_bad"}, 256'(bad), 256'(0));
        check({name, " reads_issued"}, 256'(rd_issue_cnt - b_iss), 256'(n));
        check({name, " done_pulses"}, 256'(done_cnt - b_done), 256'(1));
        check({name, " err_busy"}, 256'({o_err, o_busy}), 256'(0));
        check({name, " qbit_num_held"}, 256'(o_qbit_num), 256'(q));
        if (stall_word >= 0) begin
            check({name, " stall_data_stable"}, 256'(stable), 256'(1));
            check({name, " stall_valid_held"}, 256'(vdrop), 256'(0));
            check({name, " stall_no_extra_read"}, 256'(iss_after), 256'(iss_stall));
        end
    endtask

    task automatic run_illegal(input string name, input int q);
        int b_en, b_done;
        b_en = en_cnt; b_done = done_cnt;
        @(posedge clk); #1;
        i_qbit_num = 6'(q); i_ins_num = 16'd5; i_go = 1'b1;
        @(posedge clk); #1;
        i_go = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({name, " err_set"}, 256'(o_err), 256'(1));
        check({name, " done_pulse"}, 256'(done_cnt - b_done), 256'(1));
        check({name, " no_qea_access"}, 256'(en_cnt - b_en), 256'(0));
        check({name, " idle"}, 256'(o_busy), 256'(0));
    endtask

    initial begin
        int b_en, b_start, b_done, cyc;
        bit seen;

        rst_n = 1'b0; i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0; i_complete = 1'b0;
        qea_load = 1'b0;
        bus.i_ctx_valid = 1'b0; bus.i_ctx_word = '0; bus.i_rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_outputs",
              256'({o_busy, o_done, o_err, o_cycles, o_start, o_qbit_num, o_ctx_en, o_ctx_wea,
                    o_ctx_addr, o_ctx_data, o_state_ena, o_state_wea, o_state_addra,
                    bus.o_ctx_ready, bus.o_rd_valid, bus.o_rd_last}), 256'(0));
        check("reset_state_dina", o_state_dina, 256'(0));
        check("reset_rd_data", bus.o_rd_data, 256'(0));

        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_idle", 256'({o_busy, 1'b0}), 256'(0));
        check("post_reset_no_start", 256'(start_cnt), 256'(0));

        run_legal("runA", 4, 91, 1'b0, 1, 100, 1'b1);
        run_legal("runB", 3, 7, 1'b1, -1, int'($urandom_range(5, 40)), 1'b0);
        run_illegal("illegal_q1", 1);
        run_illegal("illegal_q19", 19);
        run_legal("runC", 2, 0, 1'b0, 0, 1, 1'b0);
        run_legal("runD", int'($urandom_range(3, 6)), int'($urandom_range(1, 20)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(1, 60)), 1'b0);

        // Abort a run from inside WAIT
        @(posedge clk); #1;
        i_qbit_num = 6'd3; i_ins_num = 16'd2; i_go = 1'b1;
        @(posedge clk); #1;
        i_go = 1'b0; bus.i_ctx_valid = 1'b1; bus.i_ctx_word = {$urandom(), $urandom()};
        @(posedge clk); #1;
        bus.i_ctx_word = {$urandom(), $urandom()};
        @(posedge clk); #1;
        bus.i_ctx_valid = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            seen = o_start;
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_start_seen", 256'(seen), 256'(1));
        repeat (10) @(posedge clk);
        #1;
        check("abort_pre_busy_cycles", 256'({o_busy, o_cycles}), 256'({1'b1, 32'd10}));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ctrl_outputs",
              256'({o_busy, o_done, o_err, o_cycles, o_start, o_qbit_num, o_ctx_en, o_ctx_wea,
                    o_ctx_addr, o_ctx_data, o_state_ena, o_state_wea, o_state_addra,
                    bus.o_ctx_ready, bus.o_rd_valid, bus.o_rd_last}), 256'(0));
        check("abort_state_dina", o_state_dina, 256'(0));
        check("abort_rd_data", bus.o_rd_data, 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        b_en = en_cnt; b_start = start_cnt; b_done = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("abort_stays_idle", 256'({o_busy, o_err}), 256'(0));
        check("abort_no_activity", 256'({en_cnt - b_en, start_cnt - b_start, done_cnt - b_done}), 256'(0));

        run_legal("runE", 5, 3, 1'b0, 2, 17, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
